// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// One bit per cycle: shift-add multiply, restoring shift-subtract divide.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               wr_ok, accept, sign_a, sign_b, div_ge;
  logic [WIDTH:0]     mul_sum, div_rs;
  logic [WIDTH-1:0]   div_diff, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod_fix;

  assign wr_ok  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept = start && wr_ok;
  assign sign_a = ~op[0] & a[WIDTH-1];
  assign sign_b = ~op[0] & b[WIDTH-1];

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : '0);
  assign div_rs   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = div_rs >= {1'b0, mb_q};
  assign div_diff = div_rs[WIDTH-1:0] - mb_q;
  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign q_fix    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign r_fix    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = accept ? S_RUN : S_IDLE;
      S_RUN:          state_d = (cnt_q == CW'(1)) ? S_FIX : S_RUN;
      S_FIX:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN, S_FIX: busy = 1'b1;
      S_DONE:       done = 1'b1;
      default:      ;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mb_d     = mb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (wr_ok && hi_we) hi_d = wd;
    if (wr_ok && lo_we) lo_d = wd;
    if (accept) begin
      acc_d    = {{WIDTH{1'b0}}, (sign_a ? -a : a)};
      mb_d     = sign_b ? -b : b;
      is_div_d = op[1];
      neg_d    = sign_a ^ sign_b;
      rneg_d   = sign_a;
      div0_d   = op[1] && (b == '0);
      cnt_d    = CW'(WIDTH);
    end
    if (state_q == S_RUN) begin
      cnt_d = cnt_q - CW'(1);
      if (is_div_q)
        acc_d = {(div_ge ? div_diff : div_rs[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
      else
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
    if (state_q == S_FIX) begin
      if (is_div_q) begin
        // b=0 leaves |a| as remainder, so hi=a falls out; only lo needs forcing
        hi_d = r_fix;
        lo_d = div0_q ? '1 : q_fix;
      end else begin
        {hi_d, lo_d} = prod_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mb_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mb_q     <= mb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
// Results are compared against a plain-arithmetic 64-bit reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wd = '0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      2'd0: begin p = sx * sy; return p; end
      2'd1: begin p = {32'b0, x} * {32'b0, y}; return p; end
      2'd2: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Present an operation and return #1 after the accepting edge
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  // Called #1 after the accepting edge; leaves the bench inside the DONE cycle
  task automatic await_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit inject, input string tag);
    int lat, nbusy;
    logic [63:0] m;
    m = model(o, x, y);
    lat = 0; nbusy = 0;
    if (inject) begin
      start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wd = 32'hDEADBEEF;
    end
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      if (lat == 5) begin start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; end
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, W'(lat), W'(W + 1));
    chk({tag, "_busy_cycles"}, W'(nbusy), W'(W + 1));
    chk({tag, "_done"}, W'(done), W'(1));
    chk({tag, "_hi"}, hi, m[63:32]);
    chk({tag, "_lo"}, lo, m[31:0]);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    launch(o, x, y);
    await_op(o, x, y, 1'b0, tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, W'(done), W'(0));
    chk({tag, "_idle_busy"}, W'(busy), W'(0));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] lo_prev, ra, rb;
    logic [1:0] ro;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));
    @(negedge clk); rst_n = 1'b1;

    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    run_op(2'd0, 32'hFFFFFFFD, 32'd7, "mult_neg");
    run_op(2'd3, 32'd100, 32'd7, "divu");
    run_op(2'd2, 32'hFFFFFFF9, 32'd2, "div_neg");
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_op(2'd3, 32'h00001234, 32'd0, "divu_zero");
    run_op(2'd2, 32'hFFFFFF00, 32'd0, "div_zero");

    // Asynchronous reset ten cycles into RUN
    launch(2'd1, 32'd6, 32'd7);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_hi", hi, '0);
    chk("midrst_lo", lo, '0);
    chk("midrst_busy", W'(busy), W'(0));
    chk("midrst_done", W'(done), W'(0));
    @(negedge clk); rst_n = 1'b1;
    run_op(2'd1, 32'd6, 32'd7, "after_rst");

    // start and MTHI/MTLO while busy are ignored
    launch(2'd0, 32'h12345678, 32'hFEDCBA98);
    await_op(2'd0, 32'h12345678, 32'hFEDCBA98, 1'b1, "inject");

    // Back-to-back start accepted in the DONE cycle
    op = 2'd3; a = 32'd1000; b = 32'd33; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", W'(busy), W'(1));
    chk("b2b_done", W'(done), W'(0));
    await_op(2'd3, 32'd1000, 32'd33, 1'b0, "b2b");
    @(posedge clk); #1;

    // MTHI in IDLE, then MTHI+MTLO together
    lo_prev = lo;
    @(negedge clk); hi_we = 1'b1; wd = 32'hCAFEF00D;
    @(posedge clk); #1; hi_we = 1'b0;
    chk("mthi_hi", hi, 32'hCAFEF00D);
    chk("mthi_lo_hold", lo, lo_prev);
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wd = 32'h0BADF00D;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    chk("mthilo_hi", hi, 32'h0BADF00D);
    chk("mthilo_lo", lo, 32'h0BADF00D);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_hi", hi, 32'h0BADF00D);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit sitting directly downstream of the register file read ports.
- Consumes the rd1/rd2 operand pair and produces the HI/LO result pair.
- HI/LO is later selected onto the register file write-data path (wd3) by MFHI/MFLO.
- Implements MULT, MULTU, DIV and DIVU with a start/busy/done handshake, one bit per cycle.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits, and a RUN phase lasts WIDTH cycles.

Ports:
clk      input   1      system clock, rising-edge active
rst_n    input   1      asynchronous active-low reset
start    input   1      request an operation; sampled only in IDLE or DONE
op       input   2      00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a        input   WIDTH  operand A / dividend (from rd1)
b        input   WIDTH  operand B / divisor (from rd2)
hi_we    input   1      MTHI: write wd into hi
lo_we    input   1      MTLO: write wd into lo
wd       input   WIDTH  data for MTHI/MTLO
hi       output  WIDTH  product upper half / remainder
lo       output  WIDTH  product lower half / quotient
busy     output  1      operation in progress
done     output  1      one-cycle pulse: hi/lo just updated by an operation

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- rst_n low (immediately, any state, including mid-operation):
  - state=IDLE; hi=0; lo=0; busy=0; done=0; internal counter, accumulator and operand latches cleared.
  - The in-flight operation is discarded.
- States: IDLE, RUN, FIX, DONE.
- IDLE: busy=0, done=0. start=1 at edge k -> latch op, a and b; compute operand magnitudes (signed ops); counter=WIDTH; go to RUN.
- RUN: busy=1. Each edge performs one iteration and decrements the counter.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract.
  - After the WIDTH-th iteration (edge k+WIDTH) -> FIX.
- FIX: busy=1. At edge k+WIDTH+1:
  - Apply sign correction and write hi/lo.
  - Go to DONE.
- DONE: busy=0, done=1 for exactly one cycle.
  - start=1 -> accepted exactly as in IDLE (back-to-back operation).
  - Otherwise -> IDLE.
- Latency: done is high during the cycle beginning at edge k+WIDTH+1. busy is high for WIDTH+1 cycles.
- Operands: a, b and op are ignored after the latching edge. start while busy=1 is ignored (no queuing).
- Multiply: {hi,lo} = full 2*WIDTH-bit product.
  - MULT negates the magnitude product iff sign(a) xor sign(b).
- Divide: lo = quotient truncated toward zero; hi = remainder.
  - Signed: quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
- Divide by zero (b=0, DIV or DIVU): full latency still applies; hi=a; lo=all ones.
- Signed overflow (DIV, a=most-negative, b=-1): lo=most-negative; hi=0.
- hi/lo hold their value between updates.
- MTHI/MTLO:
  - hi_we/lo_we take effect at the edge only when state is IDLE or DONE; ignored while busy=1.
  - hi_we together with start in the same edge: the write occurs and operands are latched; FIX later overwrites hi/lo.
  - hi_we and lo_we together: both written.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles; done high one cycle beginning 33 cycles after the start edge.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x00001234, b=0 -> hi=0x00001234, lo=0xFFFFFFFF, done after normal latency.
- Reset mid-operation:
  - Start MULTU 6*7; drop rst_n 10 cycles into RUN -> hi=lo=0 and busy=0 before the next edge.
  - After release, MULTU 6*7 -> lo=42, hi=0.
- Handshake:
  - start with new operands during RUN -> ignored, result unchanged.
  - hi_we=1, wd=0xDEADBEEF during RUN -> ignored.
  - start in the DONE cycle -> accepted, busy=1 next cycle.
  - hi_we=1, wd=0xCAFEF00D in IDLE -> hi=0xCAFEF00D next cycle.
